mode_counter: RTL and testbench
===============================

Name: mode_counter

Overview:
- Parametrised successor to the team's fixed 2-bit counter. Provides an up/down, loadable, modulo-N counter with wrap or saturate mode.
- Flags: registered overflow/underflow pulses, a sticky event flag, and a terminal-count output.
- Drives adder and arithmetic test fixtures, and serves as a general-purpose event/sequence counter in datapath blocks.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, top count value. Counting is modulo MAX_VAL+1. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  count enable.
- CLR  in  1  synchronous clear to 0.
- UP  in  1  direction, 1 = increment, 0 = decrement.
- LD  in  1  synchronous load of LD_VAL.
- LD_VAL  in  WIDTH  load value.
- STICKY_CLR  in  1  clears OV_STICKY.
- counter  out  WIDTH  current count (registered).
- OV  out  1  one-cycle pulse on an increment at MAX_VAL (registered).
- UF  out  1  one-cycle pulse on a decrement at 0 (registered).
- TC  out  1  terminal count, combinational.
- OV_STICKY  out  1  set by any OV or UF event, held until cleared.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: counter=0, OV=0, UF=0, OV_STICKY=0.
- Priority at each rising edge of clk: Reset > CLR > LD > EN. A lower-priority request in the same cycle is ignored.
- CLR: counter<=0. OV and UF are 0 in the next cycle. OV_STICKY is unaffected.
- LD: counter<=min(LD_VAL, MAX_VAL). An out-of-range LD_VAL clamps to MAX_VAL. No OV/UF is generated.
- EN=1, UP=1, counter<MAX_VAL: counter<=counter+1.
- EN=1, UP=1, counter==MAX_VAL:
  - SATURATE=0: counter<=0.
  - SATURATE=1: counter holds MAX_VAL.
  - Either mode: OV=1 for exactly the next cycle.
- EN=1, UP=0, counter>0: counter<=counter-1.
- EN=1, UP=0, counter==0:
  - SATURATE=0: counter<=MAX_VAL.
  - SATURATE=1: counter holds 0.
  - Either mode: UF=1 for exactly the next cycle.
- EN=0: counter holds. OV and UF are 0.
- Latency: counter, OV and UF update together, one cycle after the qualifying edge. OV is visible in the same cycle as the wrapped value.
- OV and UF are never asserted in the same cycle.
- Held EN in saturate mode: OV (or UF) re-pulses every cycle, i.e. it stays high continuously.
- TC = EN & ((UP & counter==MAX_VAL) | (~UP & counter==0)). It is combinational and predicts an OV/UF on the next edge, unless CLR or LD takes priority.
- OV_STICKY:
  - Set on any cycle in which OV or UF is registered high.
  - Cleared by STICKY_CLR.
  - If set and clear occur in the same cycle, set wins.
  - Reset clears it.
- Arithmetic: all next-value computation is in WIDTH bits with explicit limit compares. It never relies on natural 2**WIDTH rollover, so non-power-of-two MAX_VAL works.
- Reset mid-count: takes effect on the next edge regardless of EN/LD/CLR. Any pending OV/UF pulse is suppressed.

Decomposition:
- Package counter_pkg: direction constants (DIR_UP=1, DIR_DN=0), mode constants (MODE_WRAP=0, MODE_SAT=1), and a parameter-legality check function used in an initial assertion.
- Sub-module mode_counter_step (combinational):
  - Inputs: counter, UP, SATURATE, MAX_VAL.
  - Outputs: next value, ov_evt, uf_evt.
  - The top level holds the registers, the priority mux, TC and the sticky logic.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0, Reset for 2 cycles then EN=1, UP=1 for 12 cycles -> counter 0,1..9,0,1. OV=1 only in the cycle counter shows 0 after 9. TC=1 while counter==9. OV_STICKY=1 thereafter.
- Same config, UP=0 from counter=0 -> counter 9,8..., UF pulse aligned with the first 9. Then STICKY_CLR=1 in the same cycle as a new UF -> OV_STICKY stays 1.
- SATURATE=1, MAX_VAL=9, load 9, hold EN=1, UP=1 for 3 cycles -> counter stays 9, OV high all 3 cycles. Then UP=0 -> 8, OV=0.
- LD=1, LD_VAL=15, MAX_VAL=9 -> counter=9, no OV. LD=1 together with EN=1 and CLR=1 -> counter=0 (CLR wins).
- Count to 5, assert Reset together with EN=1 and LD=1 -> next cycle counter=0, OV=UF=OV_STICKY=0. Resume -> 1.
- WIDTH=2 defaults (MAX_VAL=3, wrap), EN=1 for 8 cycles -> 0,1,2,3,0,1,2,3. OV twice, each aligned with the 0 that follows 3, matching the legacy counter sequence.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and parameter legality check for mode_counter.
//   DIR_UP / DIR_DN     : values of the direction input
//   MODE_WRAP / MODE_SAT: values of the SATURATE parameter
//   params_ok()         : 1 when WIDTH / MAX_VAL / SATURATE form a legal configuration
package counter_pkg;

  localparam bit DIR_UP = 1'b1;
  localparam bit DIR_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic bit params_ok(input int unsigned width, input int unsigned max_val,
                                   input int unsigned saturate);
    longint unsigned lim;
    lim = (64'd1 << width) - 64'd1;
    return (width >= 2) && (width <= 32) && (max_val >= 1) &&
           (longint'(max_val) <= lim) && (saturate <= MODE_SAT);
  endfunction

endpackage

// File: rtl/mode_counter_step.sv
// Combinational next-value logic for one enabled count step.
//   i_count  : current count
//   i_up     : direction (1 = increment)
//   o_next   : value after one step, wrapping or saturating at 0 / MAX_VAL
//   o_ov_evt : step is an increment at MAX_VAL
//   o_uf_evt : step is a decrement at 0
module mode_counter_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_ov_evt,
  output logic             o_uf_evt
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  // Limits are compared explicitly so a non-power-of-two MAX_VAL never relies on
  // natural 2**WIDTH rollover.
  always_comb begin
    o_next   = i_count;
    o_ov_evt = 1'b0;
    o_uf_evt = 1'b0;
    if (i_up == DIR_UP) begin
      if (i_count == MaxVal) begin
        o_ov_evt = 1'b1;
        o_next   = (SATURATE == MODE_SAT) ? MaxVal : '0;
      end else begin
        o_next = i_count + 1'b1;
      end
    end else begin
      if (i_count == '0) begin
        o_uf_evt = 1'b1;
        o_next   = (SATURATE == MODE_SAT) ? '0 : MaxVal;
      end else begin
        o_next = i_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down, loadable, modulo-(MAX_VAL+1) counter with wrap or saturate mode.
//   i_clk        : clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_en         : count enable
//   i_clr        : synchronous clear to 0
//   i_up         : direction, 1 = increment
//   i_ld         : synchronous load of i_ld_val (clamped to MAX_VAL)
//   i_ld_val     : load value
//   i_sticky_clr : clears o_ov_sticky
//   o_counter    : registered count
//   o_ov / o_uf  : registered one-cycle overflow / underflow pulses
//   o_tc         : combinational terminal count (predicts OV/UF on the next edge)
//   o_ov_sticky  : set by any OV/UF, held until cleared
// Priority at each edge: reset > clear > load > enable.
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_up,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic             i_sticky_clr,
  output logic [WIDTH-1:0] o_counter,
  output logic             o_ov,
  output logic             o_uf,
  output logic             o_tc,
  output logic             o_ov_sticky
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  if (!params_ok(WIDTH, MAX_VAL, SATURATE)) begin : g_bad_params
    $error("mode_counter: illegal WIDTH / MAX_VAL / SATURATE combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_ov;
  logic             r_uf;
  logic             r_sticky;

  logic [WIDTH-1:0] w_step_next;
  logic             w_step_ov;
  logic             w_step_uf;
  logic [WIDTH-1:0] w_count_d;
  logic             w_ov_d;
  logic             w_uf_d;
  logic             w_sticky_d;

  mode_counter_step #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_step (
    .i_count  (r_count),
    .i_up     (i_up),
    .o_next   (w_step_next),
    .o_ov_evt (w_step_ov),
    .o_uf_evt (w_step_uf)
  );

  always_comb begin
    w_count_d = r_count;
    w_ov_d    = 1'b0;
    w_uf_d    = 1'b0;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_ld) begin
      w_count_d = (i_ld_val > MaxVal) ? MaxVal : i_ld_val;
    end else if (i_en) begin
      w_count_d = w_step_next;
      w_ov_d    = w_step_ov;
      w_uf_d    = w_step_uf;
    end
  end

  // Set beats clear both on the edge that registers an event and during the cycle
  // the event pulse is visible.
  assign w_sticky_d = (r_sticky & ~i_sticky_clr) | w_ov_d | w_uf_d | r_ov | r_uf;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count  <= '0;
      r_ov     <= 1'b0;
      r_uf     <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_count  <= w_count_d;
      r_ov     <= w_ov_d;
      r_uf     <= w_uf_d;
      r_sticky <= w_sticky_d;
    end
  end

  assign o_counter   = r_count;
  assign o_ov        = r_ov;
  assign o_uf        = r_uf;
  assign o_ov_sticky = r_sticky;
  assign o_tc        = i_en & (((i_up == DIR_UP) & (r_count == MaxVal)) |
                               ((i_up == DIR_DN) & (r_count == '0)));

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: three instances share one stimulus stream.
//   dut 0: WIDTH=4, MAX_VAL=9, wrap
//   dut 1: WIDTH=4, MAX_VAL=9, saturate
//   dut 2: WIDTH=2 defaults (MAX_VAL=3, wrap)
module tb_mode_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, up, ld, sclr;
  logic [3:0] ldv;

  logic [3:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       ov_a, uf_a, tc_a, st_a;
  logic       ov_b, uf_b, tc_b, st_b;
  logic       ov_c, uf_c, tc_c, st_c;

  mode_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_clr(clr), .i_up(up), .i_ld(ld),
    .i_ld_val(ldv), .i_sticky_clr(sclr), .o_counter(cnt_a), .o_ov(ov_a), .o_uf(uf_a),
    .o_tc(tc_a), .o_ov_sticky(st_a)
  );

  mode_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_clr(clr), .i_up(up), .i_ld(ld),
    .i_ld_val(ldv), .i_sticky_clr(sclr), .o_counter(cnt_b), .o_ov(ov_b), .o_uf(uf_b),
    .o_tc(tc_b), .o_ov_sticky(st_b)
  );

  mode_counter #(.WIDTH(2)) u_dut_c (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_clr(clr), .i_up(up), .i_ld(ld),
    .i_ld_val(ldv[1:0]), .i_sticky_clr(sclr), .o_counter(cnt_c), .o_ov(ov_c),
    .o_uf(uf_c), .o_tc(tc_c), .o_ov_sticky(st_c)
  );

  // Reference model: counts as plain integers modulo (max+1), or clipped to [0, max].
  int mx [3]  = '{9, 9, 3};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt [3] = '{0, 0, 0};
  bit m_ov [3]  = '{1'b0, 1'b0, 1'b0};
  bit m_uf [3]  = '{1'b0, 1'b0, 1'b0};
  bit m_st [3]  = '{1'b0, 1'b0, 1'b0};

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [3:0] obs_cnt(input int i);
    case (i)
      0:       return cnt_a;
      1:       return cnt_b;
      default: return {2'b00, cnt_c};
    endcase
  endfunction

  // {tc, sticky, uf, ov}
  function automatic logic [3:0] obs_flags(input int i);
    case (i)
      0:       return {tc_a, st_a, uf_a, ov_a};
      1:       return {tc_b, st_b, uf_b, ov_b};
      default: return {tc_c, st_c, uf_c, ov_c};
    endcase
  endfunction

  function automatic bit exp_tc(input int i);
    return en && ((up && m_cnt[i] == mx[i]) || (!up && m_cnt[i] == 0));
  endfunction

  // Advance the model with the inputs present at this edge, then wait past the edge.
  task automatic tick();
    int n_cnt [3];
    bit n_ov [3], n_uf [3], n_st [3];
    for (int i = 0; i < 3; i++) begin
      int lv;
      lv = (i == 2) ? int'(ldv) % 4 : int'(ldv);
      n_cnt[i] = m_cnt[i];
      n_ov[i]  = 1'b0;
      n_uf[i]  = 1'b0;
      if (rst) begin
        n_cnt[i] = 0;
        n_st[i]  = 1'b0;
      end else begin
        if (clr) begin
          n_cnt[i] = 0;
        end else if (ld) begin
          n_cnt[i] = (lv > mx[i]) ? mx[i] : lv;
        end else if (en) begin
          if (up) begin
            n_ov[i]  = (m_cnt[i] == mx[i]);
            n_cnt[i] = sat[i] ? ((m_cnt[i] + 1 > mx[i]) ? mx[i] : m_cnt[i] + 1)
                              : (m_cnt[i] + 1) % (mx[i] + 1);
          end else begin
            n_uf[i]  = (m_cnt[i] == 0);
            n_cnt[i] = sat[i] ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                              : (m_cnt[i] + mx[i]) % (mx[i] + 1);
          end
        end
        n_st[i] = n_ov[i] | n_uf[i] | m_ov[i] | m_uf[i] | (m_st[i] & ~sclr);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = n_cnt[i];
      m_ov[i]  = n_ov[i];
      m_uf[i]  = n_uf[i];
      m_st[i]  = n_st[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; up = 1'b1; ld = 1'b0; ldv = 4'd0; sclr = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs_cnt(i) !== 4'd0 || obs_flags(i) !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset dut%0d: got cnt=%0d flags=%b want cnt=0 flags=0000",
                 i, obs_cnt(i), obs_flags(i));
      end
    end
  endtask

  task automatic test_wrap_up();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      n_total++;
      if (tc_a !== (k == 10)) begin
        n_bad++;
        $display("FAIL wrap_up tc k=%0d: got %b want %b", k, tc_a, (k == 10));
      end
      tick();
      n_total++;
      if (cnt_a !== 4'(k % 10) || ov_a !== (k == 10) || uf_a !== 1'b0 || st_a !== (k >= 10)) begin
        n_bad++;
        $display("FAIL wrap_up k=%0d: got cnt=%0d ov=%b uf=%b st=%b want cnt=%0d ov=%b uf=0 st=%b",
                 k, cnt_a, ov_a, uf_a, st_a, k % 10, (k == 10), (k >= 10));
      end
    end
  endtask

  task automatic test_wrap_down();
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bit want_st;
      sclr = (k == 5) || (k == 11);
      #1;
      n_total++;
      if (tc_a !== (k == 1 || k == 11)) begin
        n_bad++;
        $display("FAIL wrap_down tc k=%0d: got %b want %b", k, tc_a, (k == 1 || k == 11));
      end
      tick();
      want_st = (k < 5) || (k == 11);
      n_total++;
      if (cnt_a !== 4'((10 - k + 10) % 10) || uf_a !== (k == 1 || k == 11) || ov_a !== 1'b0 ||
          st_a !== want_st) begin
        n_bad++;
        $display("FAIL wrap_down k=%0d: got cnt=%0d uf=%b ov=%b st=%b want cnt=%0d uf=%b ov=0 st=%b",
                 k, cnt_a, uf_a, ov_a, st_a, (20 - k) % 10, (k == 1 || k == 11), want_st);
      end
    end
    // Clear requested while the UF pulse is visible: set still wins.
    en = 1'b0; sclr = 1'b1;
    tick();
    n_total++;
    if (st_a !== 1'b1 || uf_a !== 1'b0 || cnt_a !== 4'd9) begin
      n_bad++;
      $display("FAIL sticky_hold: got st=%b uf=%b cnt=%0d want st=1 uf=0 cnt=9", st_a, uf_a, cnt_a);
    end
    tick();
    n_total++;
    if (st_a !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_clear: got st=%b want 0", st_a);
    end
    sclr = 1'b0;
  endtask

  task automatic test_saturate();
    ld = 1'b1; ldv = 4'd9; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_total++;
      if (tc_b !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_tc k=%0d: got %b want 1", k, tc_b);
      end
      tick();
      n_total++;
      if (cnt_b !== 4'd9 || ov_b !== 1'b1 || uf_b !== 1'b0) begin
        n_bad++;
        $display("FAIL sat_hold k=%0d: got cnt=%0d ov=%b uf=%b want cnt=9 ov=1 uf=0",
                 k, cnt_b, ov_b, uf_b);
      end
    end
    up = 1'b0;
    tick();
    n_total++;
    if (cnt_b !== 4'd8 || ov_b !== 1'b0 || uf_b !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_down: got cnt=%0d ov=%b uf=%b want cnt=8 ov=0 uf=0", cnt_b, ov_b, uf_b);
    end
  endtask

  task automatic test_load_priority();
    en = 1'b0; ld = 1'b1; ldv = 4'd15;
    tick();
    n_total++;
    if (cnt_a !== 4'd9 || cnt_b !== 4'd9 || cnt_c !== 2'd3 || ov_a !== 1'b0) begin
      n_bad++;
      $display("FAIL load_clamp: got a=%0d b=%0d c=%0d ov=%b want a=9 b=9 c=3 ov=0",
               cnt_a, cnt_b, cnt_c, ov_a);
    end
    ldv = 4'd4; en = 1'b1; up = 1'b1;
    tick();
    n_total++;
    if (cnt_a !== 4'd4 || ov_a !== 1'b0) begin
      n_bad++;
      $display("FAIL load_over_en: got cnt=%0d ov=%b want cnt=4 ov=0", cnt_a, ov_a);
    end
    clr = 1'b1;
    tick();
    n_total++;
    if (cnt_a !== 4'd0 || cnt_b !== 4'd0 || cnt_c !== 2'd0 || ov_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_wins: got a=%0d b=%0d c=%0d ov=%b want all 0", cnt_a, cnt_b, cnt_c, ov_a);
    end
    clr = 1'b0; ld = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    n_total++;
    if (cnt_a !== 4'd5 || st_c !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: got a=%0d st_c=%b want a=5 st_c=1", cnt_a, st_c);
    end
    rst = 1'b1; ld = 1'b1; ldv = 4'd7;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs_cnt(i) !== 4'd0 || obs_flags(i)[2:0] !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_mid dut%0d: got cnt=%0d st/uf/ov=%b want 0 000",
                 i, obs_cnt(i), obs_flags(i)[2:0]);
      end
    end
    rst = 1'b0; ld = 1'b0;
    tick();
    n_total++;
    if (cnt_a !== 4'd1) begin
      n_bad++;
      $display("FAIL resume: got %0d want 1", cnt_a);
    end
  endtask

  task automatic test_legacy_w2();
    int n_ov;
    n_ov = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ov_c === 1'b1) n_ov++;
      n_total++;
      if (cnt_c !== 2'(k % 4) || ov_c !== (k % 4 == 0)) begin
        n_bad++;
        $display("FAIL legacy k=%0d: got cnt=%0d ov=%b want cnt=%0d ov=%b",
                 k, cnt_c, ov_c, k % 4, (k % 4 == 0));
      end
    end
    n_total++;
    if (n_ov != 2) begin
      n_bad++;
      $display("FAIL legacy_ov_count: got %0d want 2", n_ov);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(99) < 2);
      clr  = ($urandom_range(99) < 5);
      ld   = ($urandom_range(99) < 10);
      ldv  = 4'($urandom_range(15));
      en   = ($urandom_range(99) < 80);
      if ($urandom_range(99) < 15) up = ~up;
      sclr = ($urandom_range(99) < 10);
      #1;
      for (int i = 0; i < 3; i++) begin
        logic [3:0] want_f;
        want_f = {exp_tc(i), m_st[i], m_uf[i], m_ov[i]};
        n_total++;
        if (obs_cnt(i) !== 4'(m_cnt[i]) || obs_flags(i) !== want_f) begin
          n_bad++;
          $display("FAIL random dut%0d cyc=%0d: got cnt=%0d tc/st/uf/ov=%b want cnt=%0d %b",
                   i, c, obs_cnt(i), obs_flags(i), m_cnt[i], want_f);
        end
        n_total++;
        if (obs_flags(i)[1] === 1'b1 && obs_flags(i)[0] === 1'b1) begin
          n_bad++;
          $display("FAIL ov_uf_both dut%0d cyc=%0d: got 11 want not both", i, c);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_reset_mid();
    test_legacy_w2();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
